// File: rtl/chipbus_slot_arbiter_if.sv
// Chip-bus slot arbiter signal bundle: DMA enables, requests, CPU request, slot grants.
// The master side drives requests and enables; the slave side is the arbiter.
interface chipbus_slot_arbiter_if #(
  parameter int HPOS_W = 8
) ();
  logic              hsync_start;
  logic              dmaen;
  logic              disken;
  logic [3:0]        auden;
  logic              spren;
  logic              copen;
  logic              blten;
  logic              bltpri;
  logic              req_disk;
  logic              disk_wr;
  logic [3:0]        req_aud;
  logic              req_spr;
  logic              req_cop;
  logic              req_blt;
  logic              blt_wr;
  logic              cpu_req;
  logic [HPOS_W-1:0] hpos;
  logic              gnt_ref;
  logic              gnt_disk;
  logic [3:0]        gnt_aud;
  logic              gnt_spr;
  logic              gnt_cop;
  logic              gnt_blt;
  logic              dma;
  logic              dmawr;
  logic              dmapri;

  modport master (
    output hsync_start, dmaen, disken, auden, spren, copen, blten, bltpri,
           req_disk, disk_wr, req_aud, req_spr, req_cop, req_blt, blt_wr, cpu_req,
    input  hpos, gnt_ref, gnt_disk, gnt_aud, gnt_spr, gnt_cop, gnt_blt, dma, dmawr, dmapri
  );

  modport slave (
    input  hsync_start, dmaen, disken, auden, spren, copen, blten, bltpri,
           req_disk, disk_wr, req_aud, req_spr, req_cop, req_blt, blt_wr, cpu_req,
    output hpos, gnt_ref, gnt_disk, gnt_aud, gnt_spr, gnt_cop, gnt_blt, dma, dmawr, dmapri
  );
endinterface

// File: rtl/chipbus_slot_arbiter.sv
// Chip-bus slot scheduler: fixed odd-slot map for refresh/disk/audio/sprite, free slots
// arbitrated copper > blitter > CPU, with a blitter hog limiter when bltpri is low.
module chipbus_slot_arbiter #(
  parameter int LINE_LEN = 227,
  parameter int HPOS_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chipbus_slot_arbiter_if.slave  bus
);
  localparam logic [HPOS_W-1:0] LAST_HPOS = HPOS_W'(LINE_LEN - 1);

  logic [HPOS_W-1:0] hpos_r,   nxt_hpos_s;
  logic              ref_r,    ref_s;
  logic              disk_r,   disk_s;
  logic [3:0]        aud_r,    aud_s;
  logic              spr_r,    spr_s;
  logic              cop_r,    cop_s;
  logic              blt_r,    blt_s;
  logic              dma_r,    dma_s;
  logic              dmawr_r,  dmawr_s;
  logic              dmapri_r, dmapri_s;
  logic [2:0]        hog_r,    hog_nxt_s;

  logic              odd_s, is_ref_s, is_disk_s, is_aud_s, is_spr_s, free_s;
  logic [1:0]        aud_idx_s;
  logic              blt_ok_s, hog_block_s;

  // Next slot number; a line restart overrides the normal wrap.
  always_comb begin
    nxt_hpos_s = hpos_r + HPOS_W'(1);
    if (bus.hsync_start) begin
      nxt_hpos_s = '0;
    end else if (hpos_r == LAST_HPOS) begin
      nxt_hpos_s = '0;
    end else begin
      nxt_hpos_s = hpos_r + HPOS_W'(1);
    end
  end

  // Fixed slot map, evaluated on the slot being decided (next hpos).
  assign odd_s     = nxt_hpos_s[0];
  assign is_ref_s  = odd_s && (nxt_hpos_s <= HPOS_W'(7));
  assign is_disk_s = odd_s && (nxt_hpos_s >= HPOS_W'(9))  && (nxt_hpos_s <= HPOS_W'(13));
  assign is_aud_s  = odd_s && (nxt_hpos_s >= HPOS_W'(15)) && (nxt_hpos_s <= HPOS_W'(21));
  assign is_spr_s  = odd_s && (nxt_hpos_s >= HPOS_W'(23)) && (nxt_hpos_s <= HPOS_W'(53));
  assign aud_idx_s = 2'((nxt_hpos_s - HPOS_W'(15)) >> 1);

  assign blt_ok_s    = bus.req_blt & bus.blten & bus.dmaen;
  // After three back-to-back blitter wins against a waiting CPU, one free slot goes to the CPU.
  assign hog_block_s = ~bus.bltpri & bus.cpu_req & (hog_r == 3'd3);

  // Slot owner for the upcoming slot.
  always_comb begin
    ref_s  = 1'b0;
    disk_s = 1'b0;
    aud_s  = 4'b0000;
    spr_s  = 1'b0;
    cop_s  = 1'b0;
    blt_s  = 1'b0;
    free_s = 1'b0;
    if (is_ref_s) begin
      ref_s = 1'b1;
    end else if (is_disk_s && bus.req_disk && bus.disken && bus.dmaen) begin
      disk_s = 1'b1;
    end else if (is_aud_s && bus.req_aud[aud_idx_s] && bus.auden[aud_idx_s] && bus.dmaen) begin
      aud_s[aud_idx_s] = 1'b1;
    end else if (is_spr_s && bus.req_spr && bus.spren && bus.dmaen) begin
      spr_s = 1'b1;
    end else begin
      free_s = 1'b1;
    end
    if (free_s && !odd_s && bus.req_cop && bus.copen && bus.dmaen) begin
      cop_s = 1'b1;
    end else if (free_s && blt_ok_s && !hog_block_s) begin
      blt_s = 1'b1;
    end else begin
      cop_s = 1'b0;
      blt_s = 1'b0;
    end
  end

  // Hog counter update and derived bus-control flags.
  always_comb begin
    hog_nxt_s = hog_r;
    if (bus.bltpri || !bus.cpu_req) begin
      hog_nxt_s = 3'd0;
    end else if (free_s && !cop_s && (hog_r == 3'd3)) begin
      hog_nxt_s = 3'd0;
    end else if (blt_s) begin
      hog_nxt_s = hog_r + 3'd1;
    end else begin
      hog_nxt_s = hog_r;
    end
    dma_s    = ref_s | disk_s | (|aud_s) | spr_s | cop_s | blt_s;
    dmawr_s  = (disk_s & bus.disk_wr) | (blt_s & bus.blt_wr);
    dmapri_s = bus.bltpri & bus.blten & bus.dmaen & bus.req_blt;
  end

  // Output and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_r   <= '0;
      ref_r    <= 1'b0;
      disk_r   <= 1'b0;
      aud_r    <= 4'b0000;
      spr_r    <= 1'b0;
      cop_r    <= 1'b0;
      blt_r    <= 1'b0;
      dma_r    <= 1'b0;
      dmawr_r  <= 1'b0;
      dmapri_r <= 1'b0;
      hog_r    <= 3'd0;
    end else begin
      hpos_r   <= nxt_hpos_s;
      ref_r    <= ref_s;
      disk_r   <= disk_s;
      aud_r    <= aud_s;
      spr_r    <= spr_s;
      cop_r    <= cop_s;
      blt_r    <= blt_s;
      dma_r    <= dma_s;
      dmawr_r  <= dmawr_s;
      dmapri_r <= dmapri_s;
      hog_r    <= hog_nxt_s;
    end
  end

  assign bus.hpos     = hpos_r;
  assign bus.gnt_ref  = ref_r;
  assign bus.gnt_disk = disk_r;
  assign bus.gnt_aud  = aud_r;
  assign bus.gnt_spr  = spr_r;
  assign bus.gnt_cop  = cop_r;
  assign bus.gnt_blt  = blt_r;
  assign bus.dma      = dma_r;
  assign bus.dmawr    = dmawr_r;
  assign bus.dmapri   = dmapri_r;
endmodule

// File: tb/tb_chipbus_slot_arbiter.sv
// Directed bench for chipbus_slot_arbiter: slot walk, fixed slots, free-slot priority,
// blitter fairness, hsync restart and asynchronous reset.
module tb_chipbus_slot_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_h = 0;

  chipbus_slot_arbiter_if #(.HPOS_W(8)) bus ();

  chipbus_slot_arbiter #(.LINE_LEN(227), .HPOS_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at hpos %0d: got %0h expected %0h", tag, exp_h, got, exp);
    end
  endtask

  // One clock; the bench tracks the slot counter independently.
  task automatic tick();
    int nh;
    nh = bus.hsync_start ? 0 : ((exp_h == 226) ? 0 : exp_h + 1);
    @(posedge clk);
    #1;
    exp_h = nh;
  endtask

  task automatic wait_to(input int h);
    for (int i = 0; i < 300 && exp_h != h; i++) tick();
    check_eq("sync_hpos", 32'(bus.hpos), 32'(h));
  endtask

  initial begin
    int hs[3];
    int cl[8];
    logic [1:0] kind[8];
    bus.hsync_start = 1'b0; bus.dmaen = 1'b0; bus.disken = 1'b0; bus.auden = 4'h0;
    bus.spren = 1'b0; bus.copen = 1'b0; bus.blten = 1'b0; bus.bltpri = 1'b0;
    bus.req_disk = 1'b0; bus.disk_wr = 1'b0; bus.req_aud = 4'h0; bus.req_spr = 1'b0;
    bus.req_cop = 1'b0; bus.req_blt = 1'b0; bus.blt_wr = 1'b0; bus.cpu_req = 1'b0;

    // Reset state
    #12;
    check_eq("rst_hpos", 32'(bus.hpos), 32'd0);
    check_eq("rst_dma", 32'(bus.dma), 32'd0);
    check_eq("rst_ref", 32'(bus.gnt_ref), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle walk over more than one line
    for (int i = 0; i < 300; i++) begin
      tick();
      check_eq("walk_hpos", 32'(bus.hpos), 32'(exp_h));
      check_eq("walk_ref", 32'(bus.gnt_ref), 32'((exp_h % 2 == 1) && (exp_h <= 7)));
      check_eq("walk_dma", 32'(bus.dma), 32'((exp_h % 2 == 1) && (exp_h <= 7)));
    end

    // Disk slots
    bus.dmaen = 1'b1; bus.disken = 1'b1; bus.req_disk = 1'b1; bus.disk_wr = 1'b1;
    wait_to(8);
    hs = '{9, 11, 13};
    foreach (hs[k]) begin
      wait_to(hs[k]);
      check_eq("disk_gnt", 32'(bus.gnt_disk), 32'd1);
      check_eq("disk_dma", 32'(bus.dma), 32'd1);
      check_eq("disk_wr", 32'(bus.dmawr), 32'd1);
      tick();
      check_eq("disk_even_idle", 32'(bus.dma), 32'd0);
    end

    // Disabled disk slots fall to the blitter
    bus.disken = 1'b0; bus.req_blt = 1'b1; bus.blten = 1'b1; bus.blt_wr = 1'b0;
    foreach (hs[k]) begin
      wait_to(hs[k]);
      check_eq("dskoff_disk", 32'(bus.gnt_disk), 32'd0);
      check_eq("dskoff_blt", 32'(bus.gnt_blt), 32'd1);
      check_eq("dskoff_wr", 32'(bus.dmawr), 32'd0);
    end
    bus.req_disk = 1'b0;

    // Copper vs blitter: 0:cop 1:ref 2:cop 8:cop 9:blt 55:blt 56:cop 57:blt
    bus.req_cop = 1'b1; bus.copen = 1'b1; bus.blt_wr = 1'b1;
    cl = '{0, 1, 2, 8, 9, 55, 56, 57};
    kind = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2};
    wait_to(100);
    foreach (cl[k]) begin
      wait_to(cl[k]);
      check_eq("cb_ref", 32'(bus.gnt_ref), 32'(kind[k] == 2'd0));
      check_eq("cb_cop", 32'(bus.gnt_cop), 32'(kind[k] == 2'd1));
      check_eq("cb_blt", 32'(bus.gnt_blt), 32'(kind[k] == 2'd2));
      check_eq("cb_dmawr", 32'(bus.dmawr), 32'(kind[k] == 2'd2));
      check_eq("cb_dma", 32'(bus.dma), 32'd1);
    end
    bus.req_cop = 1'b0; bus.blt_wr = 1'b0;

    // Blitter fairness: blt, blt, blt, cpu, repeating
    wait_to(100);
    bus.cpu_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("fair_blt", 32'(bus.gnt_blt), 32'(i % 4 != 3));
      check_eq("fair_dma", 32'(bus.dma), 32'(i % 4 != 3));
      check_eq("fair_pri", 32'(bus.dmapri), 32'd0);
    end

    // Nasty blitter takes every free slot
    bus.bltpri = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("nasty_blt", 32'(bus.gnt_blt), 32'd1);
      check_eq("nasty_pri", 32'(bus.dmapri), 32'd1);
    end

    // dmaen falling: current grant completes, next slot is the CPU's
    bus.dmaen = 1'b0;
    #2;
    check_eq("dmaoff_cur", 32'(bus.gnt_blt), 32'd1);
    tick();
    check_eq("dmaoff_next", 32'(bus.gnt_blt), 32'd0);
    check_eq("dmaoff_pri", 32'(bus.dmapri), 32'd0);
    bus.req_blt = 1'b0; bus.bltpri = 1'b0; bus.cpu_req = 1'b0; bus.dmaen = 1'b1;

    // hsync at 100 and in a refresh-to-be slot
    wait_to(100);
    bus.hsync_start = 1'b1;
    tick();
    check_eq("hsync_hpos", 32'(bus.hpos), 32'd0);
    tick();
    check_eq("hsync_ref_hpos", 32'(bus.hpos), 32'd0);
    check_eq("hsync_no_ref", 32'(bus.gnt_ref), 32'd0);
    bus.hsync_start = 1'b0;
    tick();
    check_eq("hsync_resume", 32'(bus.hpos), 32'd1);
    check_eq("hsync_ref1", 32'(bus.gnt_ref), 32'd1);

    // Async reset while the blitter holds the bus
    bus.req_blt = 1'b1;
    wait_to(110);
    check_eq("pre_rst_blt", 32'(bus.gnt_blt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_blt", 32'(bus.gnt_blt), 32'd0);
    check_eq("arst_dma", 32'(bus.dma), 32'd0);
    check_eq("arst_hpos", 32'(bus.hpos), 32'd0);
    bus.req_blt = 1'b0;
    exp_h = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_hpos", 32'(bus.hpos), 32'd1);
    check_eq("post_rst_ref", 32'(bus.gnt_ref), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
